// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch stage: sizes, start PC, FSM encoding, halt word.
package fetch_pkg;
  localparam int DATA_SIZE    = 32;
  localparam int ADDR_SIZE    = 10;
  localparam int PC_START_DEF = 'h80;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // IM powers up zeroed, so an all-zero word marks the end of the program image
  localparam logic [DATA_SIZE-1:0] HALT_WORD = '0;
endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO (output register + skid) carrying {pc, word} to decode; flush drops both entries.
module fetch_skid_buf #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          in_valid_i,
  input  logic [AW-1:0] in_pc_i,
  input  logic [DW-1:0] in_word_i,
  input  logic          out_ready_i,
  output logic          out_valid_o,
  output logic [AW-1:0] out_pc_o,
  output logic [DW-1:0] out_word_o,
  output logic          skid_valid_o
);
  logic          out_vld_q, out_vld_d, skd_vld_q, skd_vld_d;
  logic [AW-1:0] out_pc_q, out_pc_d, skd_pc_q, skd_pc_d;
  logic [DW-1:0] out_word_q, out_word_d, skd_word_q, skd_word_d;
  logic          pop;

  assign pop = out_vld_q & out_ready_i;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_pc_d   = out_pc_q;
    out_word_d = out_word_q;
    skd_vld_d  = skd_vld_q;
    skd_pc_d   = skd_pc_q;
    skd_word_d = skd_word_q;
    if (flush_i) begin
      out_vld_d = 1'b0;
      skd_vld_d = 1'b0;
    end else if (!out_vld_q || pop) begin
      if (skd_vld_q) begin
        // oldest entry advances; a same-cycle arrival refills the skid
        out_pc_d   = skd_pc_q;
        out_word_d = skd_word_q;
        out_vld_d  = 1'b1;
        skd_vld_d  = in_valid_i;
        if (in_valid_i) begin
          skd_pc_d   = in_pc_i;
          skd_word_d = in_word_i;
        end
      end else begin
        out_vld_d = in_valid_i;
        if (in_valid_i) begin
          out_pc_d   = in_pc_i;
          out_word_d = in_word_i;
        end
      end
    end else if (in_valid_i) begin
      skd_vld_d  = 1'b1;
      skd_pc_d   = in_pc_i;
      skd_word_d = in_word_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_pc_q   <= '0;
      out_word_q <= '0;
      skd_vld_q  <= 1'b0;
      skd_pc_q   <= '0;
      skd_word_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_pc_q   <= out_pc_d;
      out_word_q <= out_word_d;
      skd_vld_q  <= skd_vld_d;
      skd_pc_q   <= skd_pc_d;
      skd_word_q <= skd_word_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(in_valid_i && out_vld_q && !pop && skd_vld_q && !flush_i));

  assign out_valid_o  = out_vld_q;
  assign out_pc_o     = out_pc_q;
  assign out_word_o   = out_word_q;
  assign skid_valid_o = skd_vld_q;
endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC, IM strobes, branch redirect and FSM; buffering lives in fetch_skid_buf.
// FETCH_HALT_DET_EN: stop fetching when a zero word is captured (HALT state).
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int                  DataSize = DATA_SIZE,
  parameter int                  AddrSize = ADDR_SIZE,
  parameter logic [AddrSize-1:0] PC_START = AddrSize'(PC_START_DEF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [AddrSize-1:0] IM_address,
  output logic                enable_mem,
  output logic                enable_fetch,
  input  logic [DataSize-1:0] IMout,
  input  logic                branch_taken,
  input  logic [AddrSize-1:0] branch_target,
  output logic [DataSize-1:0] inst,
  output logic [AddrSize-1:0] inst_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic                busy
);
  logic [1:0]          state_q, state_d;
  logic [AddrSize-1:0] pc_q, pc_d, iss_pc_q, iss_pc_d;
  logic                inflight_q, inflight_d;
  logic                skid_valid, pop, issue, cap_vld, halt_hit, deliver, flush;
  logic [1:0]          load;

  assign pop  = inst_valid & inst_ready;
  // entries held once the in-flight word lands, assuming decode stalls next cycle
  assign load = 2'(inst_valid) + 2'(skid_valid) + 2'(inflight_q) - 2'(pop);
  assign issue   = (state_q == ST_RUN) && !branch_taken && (load < 2'd2);
  assign cap_vld = inflight_q && !branch_taken && (state_q == ST_RUN);
`ifdef FETCH_HALT_DET_EN
  assign halt_hit = cap_vld && (IMout == DataSize'(HALT_WORD));
`else
  assign halt_hit = 1'b0;
`endif
  assign deliver = cap_vld && !halt_hit;
  assign flush   = branch_taken && (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
`ifdef FETCH_HALT_DET_EN
      ST_RUN:  if (halt_hit) state_d = ST_HALT;
      ST_HALT: if (branch_taken) state_d = ST_RUN;
`else
      ST_RUN:  state_d = ST_RUN;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (branch_taken)                     pc_d = branch_target;
    else if (state_q == ST_IDLE && start) pc_d = PC_START;
    else if (issue)                       pc_d = pc_q + AddrSize'(1);
  end

  assign iss_pc_d   = issue ? pc_q : iss_pc_q;
  assign inflight_d = issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= PC_START;
      iss_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      iss_pc_q   <= iss_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_skid_buf #(.DW(DataSize), .AW(AddrSize)) u_buf (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .in_valid_i   (deliver),
    .in_pc_i      (iss_pc_q),
    .in_word_i    (IMout),
    .out_ready_i  (inst_ready),
    .out_valid_o  (inst_valid),
    .out_pc_o     (inst_pc),
    .out_word_o   (inst),
    .skid_valid_o (skid_valid)
  );

  assign IM_address   = pc_q;
  assign enable_mem   = issue;
  assign enable_fetch = issue;
  assign busy         = (state_q == ST_RUN);
endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: registered IM model, queued expectations, negedge monitor.
module tb_inst_fetch;
  typedef struct packed { logic [9:0] pc; logic [31:0] w; } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, inst_ready, branch_taken;
  logic [9:0]  branch_target, IM_address, inst_pc;
  logic        enable_mem, enable_fetch, inst_valid, busy;
  logic [31:0] IMout, inst;
  // second instance with PC_START near the top of the address space
  logic        start_w, em_w, ef_w, iv_w, busy_w, br_w;
  logic [9:0]  ima_w, ipc_w, tgt_w;
  logic [31:0] imout_w, inst_w;

  logic [31:0] mem [0:1023];
  exp_t        exp_q[$], wq[$];
  int          n_chk = 0, n_fail = 0;
  logic        prev_stall = 1'b0, prev_flush = 1'b1;
  logic [41:0] prev_val = '0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .rst(rst), .start(start), .IM_address(IM_address),
    .enable_mem(enable_mem), .enable_fetch(enable_fetch), .IMout(IMout),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .busy(busy)
  );

  inst_fetch #(.PC_START(10'h3FE)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .IM_address(ima_w),
    .enable_mem(em_w), .enable_fetch(ef_w), .IMout(imout_w),
    .branch_taken(br_w), .branch_target(tgt_w),
    .inst(inst_w), .inst_pc(ipc_w), .inst_valid(iv_w),
    .inst_ready(1'b1), .busy(busy_w)
  );

  initial for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);

  always @(posedge clk) begin
    if (enable_mem && enable_fetch) IMout <= mem[IM_address];
    if (em_w && ef_w) imout_w <= mem[ima_w];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] pc);
    exp_q.push_back({pc, 32'hA000_0000 | 32'(pc)});
  endtask

  // monitor: every accepted word must match the head of the expectation queue
  always @(negedge clk) begin
    exp_t e;
    if (!rst && prev_stall && !prev_flush) begin
      chk("stall_hold_valid", 64'(inst_valid), 64'd1);
      chk("stall_hold_data", 64'({inst_pc, inst}), 64'(prev_val));
    end
    if (!rst && inst_valid && inst_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pop: got pc %0h with nothing expected", inst_pc);
      end else begin
        e = exp_q.pop_front();
        if ({inst_pc, inst} !== {e.pc, e.w}) begin
          n_fail++;
          $display("FAIL pop: got pc %0h inst %0h expected pc %0h inst %0h", inst_pc, inst, e.pc, e.w);
        end
      end
    end
    if (!rst && iv_w) begin
      n_chk++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL wrap_unexpected: got pc %0h", ipc_w);
      end else begin
        e = wq.pop_front();
        if ({ipc_w, inst_w} !== {e.pc, e.w}) begin
          n_fail++;
          $display("FAIL wrap_pop: got pc %0h inst %0h expected pc %0h inst %0h", ipc_w, inst_w, e.pc, e.w);
        end
      end
    end
    prev_stall = inst_valid && !inst_ready;
    prev_val   = {inst_pc, inst};
    prev_flush = rst || branch_taken;
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; inst_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
    start_w = 1'b0; br_w = 1'b0; tgt_w = '0;
    repeat (2) tick;
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_inst_pc", 64'(inst_pc), 64'd0);
    chk("rst_enable_fetch", 64'(enable_fetch), 64'd0);
    chk("rst_enable_mem", 64'(enable_mem), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_im_address", 64'(IM_address), 64'h80);
    rst = 1'b0;
    tick;
    chk("idle_enable_fetch", 64'(enable_fetch), 64'd0);

    // streaming from PC_START with decode always ready
    for (int p = 'h80; p < 'h90; p++) push(10'(p));
    inst_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0; #1;
    chk("lat0_busy", 64'(busy), 64'd1);
    chk("lat0_fetch", 64'(enable_fetch), 64'd1);
    chk("lat0_addr", 64'(IM_address), 64'h80);
    chk("lat0_valid", 64'(inst_valid), 64'd0);
    tick;
    chk("lat1_valid", 64'(inst_valid), 64'd0);
    chk("lat1_addr", 64'(IM_address), 64'h81);
    tick;
    chk("lat2_valid", 64'(inst_valid), 64'd1);
    chk("lat2_pc", 64'(inst_pc), 64'h80);
    chk("lat2_fetch", 64'(enable_fetch), 64'd1);
    repeat (2) begin
      tick;
      chk("stream_fetch", 64'(enable_fetch), 64'd1);
    end

    // decode stall for 3 cycles: fetch must back off, no word lost
    inst_ready = 1'b0;
    repeat (3) begin
      #1;
      chk("stall_fetch_off", 64'(enable_fetch), 64'd0);
      tick;
    end
    inst_ready = 1'b1;
    repeat (4) tick;

    // redirect with a full buffer
    inst_ready = 1'b0;
    repeat (3) tick;
    chk("full_fetch_off", 64'(enable_fetch), 64'd0);
    branch_taken = 1'b1; branch_target = 10'h200;
    tick;
    branch_taken = 1'b0;
    exp_q.delete();
    for (int p = 'h200; p < 'h210; p++) push(10'(p));
    #1;
    chk("redir0_valid", 64'(inst_valid), 64'd0);
    chk("redir0_addr", 64'(IM_address), 64'h200);
    chk("redir0_fetch", 64'(enable_fetch), 64'd1);
    tick;
    chk("redir1_valid", 64'(inst_valid), 64'd0);
    tick;
    chk("redir2_valid", 64'(inst_valid), 64'd1);
    chk("redir2_pc", 64'(inst_pc), 64'h200);
    chk("redir2_inst", 64'(inst), 64'hA000_0200);
    inst_ready = 1'b1;
    repeat (4) tick;

    // redirect while streaming: the pop in the redirect cycle still counts
    branch_taken = 1'b1; branch_target = 10'h3FE;
    tick;
    branch_taken = 1'b0;
    exp_q.delete();
    push(10'h3FE); push(10'h3FF);
    for (int p = 0; p < 8; p++) push(10'(p));
    repeat (6) tick;
    n = exp_q.size();
    chk("wrap_branch_delivered", 64'(n <= 7), 64'd1);

    // reset mid-stream discards everything
    rst = 1'b1;
    tick;
    rst = 1'b0; #1;
    exp_q.delete();
    chk("midrst_valid", 64'(inst_valid), 64'd0);
    chk("midrst_fetch", 64'(enable_fetch), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_addr", 64'(IM_address), 64'h80);
    tick;
    chk("midrst_idle_fetch", 64'(enable_fetch), 64'd0);
    for (int p = 'h80; p < 'h90; p++) push(10'(p));
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    n = exp_q.size();
    chk("restart_delivered", 64'(n <= 13), 64'd1);

    // PC_START = 'h3FE instance wraps to 0
    wq.push_back({10'h3FE, 32'hA000_03FE});
    wq.push_back({10'h3FF, 32'hA000_03FF});
    for (int p = 0; p < 8; p++) wq.push_back({10'(p), 32'hA000_0000 | 32'(p)});
    start_w = 1'b1;
    tick;
    start_w = 1'b0;
    repeat (5) tick;
    n = wq.size();
    chk("wrap_start_delivered", 64'(n <= 7), 64'd1);

`ifdef FETCH_HALT_DET_EN
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_q.delete();
    wq.delete();
    mem['h83] = 32'h0;
    push(10'h80); push(10'h81); push(10'h82);
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (8) tick;
    chk("halt_busy", 64'(busy), 64'd0);
    chk("halt_fetch", 64'(enable_fetch), 64'd0);
    chk("halt_drained", 64'(exp_q.size()), 64'd0);
    push(10'h80); push(10'h81); push(10'h82);
    branch_taken = 1'b1; branch_target = 10'h80;
    tick;
    branch_taken = 1'b0; #1;
    chk("halt_resume_busy", 64'(busy), 64'd1);
    chk("halt_resume_fetch", 64'(enable_fetch), 64'd1);
    repeat (8) tick;
    chk("halt_resume_drained", 64'(exp_q.size()), 64'd0);
    mem['h83] = 32'hA000_0083;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
